// File: rtl/coin_vend_if.sv
// Coin/vend controller handshake bundle.
// slave  : the controller (takes coins, selections, ack; drives credit/dispense/change).
// master : the machine side (acceptor, buttons, dispenser, hopper).
interface coin_vend_if #(
    parameter int NUM_DRINKS = 4,
    parameter int VAL_W      = 12
);
    localparam int IDX_W = (NUM_DRINKS > 1) ? $clog2(NUM_DRINKS) : 1;

    logic                  coin_lo;
    logic                  coin_hi;
    logic [NUM_DRINKS-1:0] drink_sel;
    logic                  cancel;
    logic                  dispense_ack;

    logic [VAL_W-1:0]      credit;
    logic [VAL_W-1:0]      price_out;
    logic                  dispense_req;
    logic [IDX_W-1:0]      drink_idx;
    logic                  change_lo;
    logic                  change_hi;
    logic [VAL_W-1:0]      change_total;
    logic                  coin_reject;
    logic                  insufficient;
    logic                  busy;

    modport slave (
        input  coin_lo, coin_hi, drink_sel, cancel, dispense_ack,
        output credit, price_out, dispense_req, drink_idx, change_lo, change_hi,
               change_total, coin_reject, insufficient, busy
    );

    modport master (
        output coin_lo, coin_hi, drink_sel, cancel, dispense_ack,
        input  credit, price_out, dispense_req, drink_idx, change_lo, change_hi,
               change_total, coin_reject, insufficient, busy
    );
endinterface

// File: rtl/coin_vend_controller.sv
// Coin/vending controller: credit accumulation, drink selection against a
// fixed price table, dispense handshake, then greedy coin-by-coin change.
// Build option: define COIN_REJECT_EN to reject coins that would push credit
// above MAX_CREDIT instead of clamping the credit.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | no credit held, waiting for coins
// S_CREDIT | credit > 0, accepting coins, selection or cancel
// S_VEND   | dispense_req held until dispense_ack
// S_CHANGE | paying out remaining credit, one coin per cycle
module coin_vend_controller #(
    parameter int NUM_DRINKS = 4,
    parameter int VAL_W      = 12,
    parameter int COIN_LO    = 100,
    parameter int COIN_HI    = 500,
    parameter int MAX_CREDIT = 2000,
    parameter logic [NUM_DRINKS*VAL_W-1:0] PRICE_TABLE = {12'd1200, 12'd700, 12'd500, 12'd300}
) (
    input logic        clk,
    input logic        rst,
    coin_vend_if.slave bus
);
    localparam int IDX_W = (NUM_DRINKS > 1) ? $clog2(NUM_DRINKS) : 1;

    typedef logic [VAL_W-1:0] val_t;
    typedef logic [VAL_W+1:0] wide_t;
    typedef logic [IDX_W-1:0] idx_t;

    // Two extra bits cover credit plus both coins without overflow.
    localparam wide_t LO_W  = wide_t'(COIN_LO);
    localparam wide_t HI_W  = wide_t'(COIN_HI);
    localparam wide_t MAX_W = wide_t'(MAX_CREDIT);
    localparam val_t  LO_V  = val_t'(COIN_LO);
    localparam val_t  HI_V  = val_t'(COIN_HI);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CREDIT,
        S_VEND,
        S_CHANGE
    } state_t;

    state_t state_q, state_n;
    val_t   credit_q, credit_n;
    val_t   price_q, price_n;
    idx_t   idx_q, idx_n;
    val_t   total_q, total_n;
    logic   req_q, req_n;
    logic   chg_lo_q, chg_lo_n;
    logic   chg_hi_q, chg_hi_n;
    logic   reject_q, reject_n;
    logic   insuf_q, insuf_n;
    logic   busy_q, busy_n;

    logic   coin_any;
    wide_t  coin_sum;
    logic   coin_rej;
    logic   sel_found;
    idx_t   sel_idx;
    val_t   sel_price;

    assign coin_any = bus.coin_lo | bus.coin_hi;

    // Lowest set selection bit wins; look up its price.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_price = '0;
        for (int i = 0; i < NUM_DRINKS; i++) begin
            if (bus.drink_sel[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = idx_t'(i);
                sel_price = PRICE_TABLE[i*VAL_W +: VAL_W];
            end
        end
    end

    // Credit after this cycle's coins, with the over-cap policy applied.
    always_comb begin
        coin_sum = wide_t'(credit_q);
        coin_rej = 1'b0;
`ifdef COIN_REJECT_EN
        if (bus.coin_hi) begin
            if (coin_sum + HI_W > MAX_W) coin_rej = 1'b1;
            else                         coin_sum = coin_sum + HI_W;
        end
        if (bus.coin_lo) begin
            if (coin_sum + LO_W > MAX_W) coin_rej = 1'b1;
            else                         coin_sum = coin_sum + LO_W;
        end
`else
        if (bus.coin_hi) coin_sum = coin_sum + HI_W;
        if (bus.coin_lo) coin_sum = coin_sum + LO_W;
        if (coin_sum > MAX_W) coin_sum = MAX_W;
`endif
    end

    // Next-state and next-output decode; pulses default low, holds default to current.
    always_comb begin
        state_n  = state_q;
        credit_n = credit_q;
        price_n  = price_q;
        idx_n    = idx_q;
        total_n  = total_q;
        req_n    = req_q;
        chg_lo_n = 1'b0;
        chg_hi_n = 1'b0;
        reject_n = 1'b0;
        insuf_n  = 1'b0;

        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (coin_any) begin
                    // Coins take the cycle; a held selection is seen next cycle.
                    credit_n = val_t'(coin_sum);
                    reject_n = coin_rej;
                    state_n  = (coin_sum == '0) ? S_IDLE : S_CREDIT;
                    // A cancel arriving with a coin refunds the coin too.
                    if (state_q == S_CREDIT && bus.cancel) begin
                        total_n = val_t'(coin_sum);
                        state_n = S_CHANGE;
                    end
                end else if (state_q == S_CREDIT && bus.cancel) begin
                    total_n = credit_q;
                    state_n = S_CHANGE;
                end else if (sel_found) begin
                    if (state_q == S_CREDIT && credit_q >= sel_price) begin
                        idx_n    = sel_idx;
                        price_n  = sel_price;
                        credit_n = credit_q - sel_price;
                        total_n  = credit_q - sel_price;
                        req_n    = 1'b1;
                        state_n  = S_VEND;
                    end else begin
                        insuf_n = 1'b1;
                    end
                end
            end
            S_VEND: begin
                reject_n = coin_any;
                if (bus.dispense_ack) begin
                    req_n   = 1'b0;
                    state_n = S_CHANGE;
                end
            end
            S_CHANGE: begin
                reject_n = coin_any;
                if (credit_q >= HI_V) begin
                    chg_hi_n = 1'b1;
                    credit_n = credit_q - HI_V;
                end else if (credit_q >= LO_V) begin
                    chg_lo_n = 1'b1;
                    credit_n = credit_q - LO_V;
                end else begin
                    // Sub-coin residue is unreachable with valid prices; drop it.
                    credit_n = '0;
                    state_n  = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n == S_VEND) || (state_n == S_CHANGE);
    end

    // State and registered outputs; reset aborts any transaction outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            price_q  <= '0;
            idx_q    <= '0;
            total_q  <= '0;
            req_q    <= 1'b0;
            chg_lo_q <= 1'b0;
            chg_hi_q <= 1'b0;
            reject_q <= 1'b0;
            insuf_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            credit_q <= credit_n;
            price_q  <= price_n;
            idx_q    <= idx_n;
            total_q  <= total_n;
            req_q    <= req_n;
            chg_lo_q <= chg_lo_n;
            chg_hi_q <= chg_hi_n;
            reject_q <= reject_n;
            insuf_q  <= insuf_n;
            busy_q   <= busy_n;
        end
    end

    assign bus.credit       = credit_q;
    assign bus.price_out    = price_q;
    assign bus.dispense_req = req_q;
    assign bus.drink_idx    = idx_q;
    assign bus.change_lo    = chg_lo_q;
    assign bus.change_hi    = chg_hi_q;
    assign bus.change_total = total_q;
    assign bus.coin_reject  = reject_q;
    assign bus.insufficient = insuf_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_coin_vend_controller.sv
// Directed bench for coin_vend_controller with the default price table
// {1200, 700, 500, 300} and coins 100/500, cap 2000.
module tb_coin_vend_controller;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   n_lo;
    int   n_hi;
    int   lo0;
    int   hi0;

    coin_vend_if #(.NUM_DRINKS(4), .VAL_W(12)) bus ();

    coin_vend_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count change pulses away from the active edge.
    always @(negedge clk) begin
        if (bus.change_lo) n_lo = n_lo + 1;
        if (bus.change_hi) n_hi = n_hi + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_coin(input logic hi, input logic lo);
        bus.coin_hi = hi;
        bus.coin_lo = lo;
        cycle();
        bus.coin_hi = 1'b0;
        bus.coin_lo = 1'b0;
    endtask

    task automatic press(input logic [3:0] sel);
        bus.drink_sel = sel;
        cycle();
        bus.drink_sel = '0;
    endtask

    task automatic do_cancel();
        bus.cancel = 1'b1;
        cycle();
        bus.cancel = 1'b0;
    endtask

    task automatic do_ack();
        bus.dispense_ack = 1'b1;
        cycle();
        bus.dispense_ack = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 50 && bus.busy; k++) cycle();
        check(tag, bus.busy, 0);
    endtask

    task automatic snap();
        lo0 = n_lo;
        hi0 = n_hi;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n_lo   = 0;
        n_hi   = 0;
        bus.coin_lo      = 1'b0;
        bus.coin_hi      = 1'b0;
        bus.drink_sel    = '0;
        bus.cancel       = 1'b0;
        bus.dispense_ack = 1'b0;
        rst = 1'b1;
        cycle();
        cycle();
        check("rst_credit", bus.credit, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_req", bus.dispense_req, 0);
        check("rst_total", bus.change_total, 0);
        rst = 1'b0;
        cycle();

        // Selection with no credit, and ack outside VEND.
        press(4'b0001);
        check("idle_insuf", bus.insufficient, 1);
        check("idle_insuf_busy", bus.busy, 0);
        do_ack();
        check("stray_ack_busy", bus.busy, 0);
        check("stray_ack_req", bus.dispense_req, 0);

        // Simultaneous coins credit 600, cancel returns 500 + 100.
        snap();
        pulse_coin(1'b1, 1'b1);
        check("both_coins_credit", bus.credit, 600);
        do_cancel();
        check("cancel600_busy", bus.busy, 1);
        check("cancel600_total", bus.change_total, 600);
        wait_idle("cancel600_idle");
        check("cancel600_hi", n_hi - hi0, 1);
        check("cancel600_lo", n_lo - lo0, 1);
        check("cancel600_credit", bus.credit, 0);

        // Exact payment for drink 2 (700): no change.
        snap();
        pulse_coin(1'b1, 1'b0);
        pulse_coin(1'b0, 1'b1);
        pulse_coin(1'b0, 1'b1);
        check("t1_credit", bus.credit, 700);
        press(4'b0100);
        check("t1_busy", bus.busy, 1);
        check("t1_req", bus.dispense_req, 1);
        check("t1_idx", bus.drink_idx, 2);
        check("t1_price", bus.price_out, 700);
        check("t1_total", bus.change_total, 0);
        cycle();
        cycle();
        cycle();
        check("t1_req_held", bus.dispense_req, 1);
        do_ack();
        check("t1_req_drop", bus.dispense_req, 0);
        wait_idle("t1_idle");
        check("t1_no_hi", n_hi - hi0, 0);
        check("t1_no_lo", n_lo - lo0, 0);

        // 1500 credit, drink 0 (300): change 500,500,100,100 back to back.
        pulse_coin(1'b1, 1'b0);
        pulse_coin(1'b1, 1'b0);
        pulse_coin(1'b1, 1'b0);
        check("t2_credit", bus.credit, 1500);
        press(4'b0001);
        check("t2_idx", bus.drink_idx, 0);
        check("t2_total", bus.change_total, 1200);
        check("t2_credit_after", bus.credit, 1200);
        do_ack();
        check("t2_c0_hi", bus.change_hi, 0);
        cycle();
        check("t2_c1_hi", bus.change_hi, 1);
        check("t2_c1_credit", bus.credit, 700);
        cycle();
        check("t2_c2_hi", bus.change_hi, 1);
        check("t2_c2_credit", bus.credit, 200);
        cycle();
        check("t2_c3_hi", bus.change_hi, 0);
        check("t2_c3_lo", bus.change_lo, 1);
        cycle();
        check("t2_c4_lo", bus.change_lo, 1);
        check("t2_c4_credit", bus.credit, 0);
        cycle();
        check("t2_idle", bus.busy, 0);
        check("t2_total_held", bus.change_total, 1200);

        // 200 credit, drink 1 (500) refused, then cancel.
        snap();
        pulse_coin(1'b0, 1'b1);
        pulse_coin(1'b0, 1'b1);
        press(4'b0010);
        check("t3_insuf", bus.insufficient, 1);
        check("t3_credit", bus.credit, 200);
        check("t3_busy", bus.busy, 0);
        cycle();
        check("t3_insuf_pulse", bus.insufficient, 0);
        do_cancel();
        check("t3_total", bus.change_total, 200);
        wait_idle("t3_idle");
        check("t3_lo", n_lo - lo0, 2);
        check("t3_hi", n_hi - hi0, 0);

        // 1000 credit, two buttons: lowest index (drink 1, 500) wins.
        snap();
        pulse_coin(1'b1, 1'b0);
        pulse_coin(1'b1, 1'b0);
        press(4'b1010);
        check("t4_idx", bus.drink_idx, 1);
        check("t4_price", bus.price_out, 500);
        check("t4_total", bus.change_total, 500);
        do_ack();
        wait_idle("t4_idle");
        check("t4_hi", n_hi - hi0, 1);
        check("t4_lo", n_lo - lo0, 0);

        // Over-cap coin, coin during VEND, then reset in CHANGE with 800 left.
        pulse_coin(1'b1, 1'b0);
        pulse_coin(1'b1, 1'b0);
        pulse_coin(1'b1, 1'b0);
        pulse_coin(1'b1, 1'b0);
        check("t5_credit4", bus.credit, 2000);
        check("t5_reject4", bus.coin_reject, 0);
        pulse_coin(1'b1, 1'b0);
        check("t5_credit5", bus.credit, 2000);
`ifdef COIN_REJECT_EN
        check("t5_reject5", bus.coin_reject, 1);
`else
        check("t5_reject5", bus.coin_reject, 0);
`endif
        press(4'b1000);
        check("t5_idx", bus.drink_idx, 3);
        check("t5_credit_vend", bus.credit, 800);
        pulse_coin(1'b0, 1'b1);
        check("t5_vend_reject", bus.coin_reject, 1);
        check("t5_vend_credit", bus.credit, 800);
        do_ack();
        check("t5_change_busy", bus.busy, 1);
        check("t5_change_credit", bus.credit, 800);
        snap();
        rst = 1'b1;
        #1;
        check("t5_rst_credit", bus.credit, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_total", bus.change_total, 0);
        check("t5_rst_idx", bus.drink_idx, 0);
        check("t5_rst_price", bus.price_out, 0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        cycle();
        cycle();
        check("t5_no_hi", n_hi - hi0, 0);
        check("t5_no_lo", n_lo - lo0, 0);
        check("t5_post_busy", bus.busy, 0);
        check("t5_post_credit", bus.credit, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coin_vend_controller.md
Name: coin_vend_controller

Overview:
Parametrised next-generation coin/vending controller. Accumulates credit from two coin denominations, accepts one of NUM_DRINKS selections against a compile-time price table, and handshakes a dispense request with the drink mechanism. It then returns change as a greedy sequence of coin pulses. Sits between the coin acceptor/selection buttons and the dispenser/change hopper, and replaces the single-shot change computation with a sequenced FSM.

Parameters:
NUM_DRINKS, 4, number of selectable drinks (1..16)
VAL_W, 12, width of credit/price/change arithmetic
COIN_LO, 100, value of small coin (accepted and returned)
COIN_HI, 500, value of large coin (accepted and returned)
MAX_CREDIT, 2000, maximum credit held
PRICE_TABLE, {12'd1200,12'd700,12'd500,12'd300}, packed NUM_DRINKS*VAL_W prices; drink i at bits [i*VAL_W +: VAL_W]; every price a nonzero multiple of COIN_LO

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
coin_lo  in  1  one-cycle pulse: small coin inserted
coin_hi  in  1  one-cycle pulse: large coin inserted
drink_sel  in  NUM_DRINKS  selection buttons, level or pulse
cancel  in  1  one-cycle pulse: refund entire credit
dispense_ack  in  1  dispenser finished (readyIn equivalent)
credit  out  VAL_W  current credit
price_out  out  VAL_W  price of latched drink
dispense_req  out  1  held high until dispense_ack
drink_idx  out  $clog2(NUM_DRINKS) (min 1)  latched drink index
change_lo  out  1  one-cycle pulse: return one small coin
change_hi  out  1  one-cycle pulse: return one large coin
change_total  out  VAL_W  total change of last transaction, held until next vend/cancel
coin_reject  out  1  one-cycle pulse: inserted coin not credited
insufficient  out  1  one-cycle pulse: selection with credit < price
busy  out  1  high in VEND and CHANGE

Behaviour:
- Reset: all outputs 0, credit 0, state IDLE. Reset mid-transaction aborts; no change emitted.
- States: IDLE (credit==0), CREDIT (credit>0), VEND, CHANGE. All outputs registered; one-cycle latency from input pulse to effect.
- IDLE/CREDIT coin pulse: credit += value; IDLE->CREDIT. coin_lo and coin_hi in the same cycle: both credited (sum), subject to cap rule.
- Cap rule (no macro): sum exceeding MAX_CREDIT clamps credit to MAX_CREDIT; no reject.
- Selection in CREDIT: lowest set index of drink_sel wins. credit >= price -> latch drink_idx/price_out, credit -= price, change_total <= credit-price, -> VEND. Otherwise pulse insufficient, stay. Selection in IDLE: pulse insufficient.
- Coin and selection in the same cycle: coin credited first; selection is evaluated next cycle if still asserted.
- cancel in CREDIT: change_total <= credit, -> CHANGE (no dispense). cancel has priority over selection in the same cycle. cancel in IDLE ignored.
- VEND: dispense_req=1 from entry until the cycle dispense_ack is sampled high; then -> CHANGE. ack asserted outside VEND ignored.
- CHANGE: one action per cycle on remaining credit r: r>=COIN_HI -> change_hi pulse, r-=COIN_HI; else r>=COIN_LO -> change_lo pulse, r-=COIN_LO; r==0 -> IDLE (dispense_req 0, busy 0).
- Coins arriving in VEND/CHANGE: coin_reject pulse, not credited. drink_sel/cancel ignored.
- Arithmetic unsigned VAL_W; no wrap reachable because credit <= MAX_CREDIT < 2^VAL_W.

Optional Feature:
COIN_REJECT_EN: when defined, a coin whose credit would exceed MAX_CREDIT is not credited and coin_reject pulses. Simultaneous coins are evaluated as hi first, then lo, each rejected independently. When undefined, clamp rule above applies and coin_reject fires only in VEND/CHANGE.

Test Plan:
- coin_hi, coin_lo, coin_lo (700), select drink 2 (700) -> VEND, drink_idx=2, dispense_req held until ack; change_total=0; return to IDLE with no change pulses.
- coin_hi x3 (1500), select drink 0 (300) -> after ack: change_hi x2, change_lo x2 on consecutive cycles, change_total=1200, credit 0.
- coin_lo x2 (200), select drink 1 (500) -> insufficient pulse, credit stays 200; cancel -> change_lo x2, IDLE.
- 1000 credit, drink_sel=4'b1010 -> drink 1 chosen, change 500 as one change_hi.
- coin_hi x5 with COIN_REJECT_EN: 5th coin rejected, credit 2000; without: credit clamps to 2000, no reject; coin inserted during VEND -> coin_reject.
- rst asserted in CHANGE with 800 remaining -> immediate IDLE, all outputs 0, no further pulses.
